// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster traversal scheduler.
// Contents:
//   COORD_W/EDGE_W/DELTA_W/AREA_W : datapath widths.
//   walker_state_t                : traversal FSM states.
//   frag_t                        : fragment record handed to the interpolator.
//   edges_inside()                : pixel-inside test on three edge values.
//   sext_delta()                  : sign-extends a per-pixel delta to accumulator width.
package raster_pkg;

  localparam int COORD_W = 12;
  localparam int EDGE_W  = 25;
  localparam int DELTA_W = 17;
  localparam int AREA_W  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } walker_state_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [EDGE_W-1:0]  w0;
    logic signed [EDGE_W-1:0]  w1;
    logic signed [EDGE_W-1:0]  w2;
    logic [AREA_W-1:0]         area;
  } frag_t;

  // A pixel is inside when every edge value is non-negative; zero counts as inside.
  function automatic logic edges_inside(input logic signed [EDGE_W-1:0] w0,
                                        input logic signed [EDGE_W-1:0] w1,
                                        input logic signed [EDGE_W-1:0] w2);
    return !(w0[EDGE_W-1] | w1[EDGE_W-1] | w2[EDGE_W-1]);
  endfunction

  function automatic logic signed [EDGE_W-1:0] sext_delta(input logic signed [DELTA_W-1:0] d);
    return {{(EDGE_W-DELTA_W){d[DELTA_W-1]}}, d};
  endfunction

endpackage

// File: rtl/edge_stepper.sv
// One edge-function accumulator pair for the raster walker.
// Ports:
//   clk       : clock.
//   load      : capture start value and deltas (row and current both = start).
//   step_col  : advance one pixel in x (cur += dl_col).
//   step_row  : wrap to next row (row += dl_row, cur = new row).
//   start     : edge value at the first pixel of the box.
//   dl_col    : signed delta per +1 x.
//   dl_row    : signed delta per +1 y.
//   cur       : edge value at the pixel being evaluated.
// Holds no control state, so it carries no reset; the walker FSM decides
// when its contents are meaningful. Arithmetic wraps modulo 2^EDGE_W.
module edge_stepper
  import raster_pkg::*;
(
  input  logic                      clk,
  input  logic                      load,
  input  logic                      step_col,
  input  logic                      step_row,
  input  logic signed [EDGE_W-1:0]  start,
  input  logic signed [DELTA_W-1:0] dl_col,
  input  logic signed [DELTA_W-1:0] dl_row,
  output logic signed [EDGE_W-1:0]  cur
);

  logic signed [EDGE_W-1:0] row_p0;
  logic signed [EDGE_W-1:0] cur_p0;
  logic signed [EDGE_W-1:0] dcol_p0;
  logic signed [EDGE_W-1:0] drow_p0;
  logic signed [EDGE_W-1:0] row_next;

  assign row_next = row_p0 + drow_p0;

  always_ff @(posedge clk) begin
    if (load) begin
      row_p0  <= start;
      cur_p0  <= start;
      dcol_p0 <= sext_delta(dl_col);
      drow_p0 <= sext_delta(dl_row);
    end else if (step_row) begin
      // Start of the next row is the saved row origin plus one row delta.
      row_p0 <= row_next;
      cur_p0 <= row_next;
    end else if (step_col) begin
      cur_p0 <= cur_p0 + dcol_p0;
    end
  end

  assign cur = cur_p0;

endmodule

// File: rtl/raster_walker.sv
// Raster traversal scheduler: takes one triangle setup packet, walks the
// bounding box row-major at one pixel per cycle and emits covered,
// on-screen fragments with valid/busy backpressure.
// Ports:
//   clock_i, reset_i            : clock, synchronous active-high reset.
//   area_i                      : twice triangle area (20.4 unsigned).
//   dl_w*_col_i / dl_w*_row_i   : signed per-pixel / per-row edge deltas.
//   w*_row_i                    : edge values at (x_min, y_min).
//   x_min_i..y_max_i            : signed pixel bounding box.
//   valid_i / busy_o            : setup packet handshake.
//   frag_*_o, valid_o / busy_i  : fragment output handshake.
//   tri_done_o                  : one-cycle pulse at end of each triangle.
module raster_walker
  import raster_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [AREA_W-1:0]         area_i,
  input  logic signed [DELTA_W-1:0] dl_w0_col_i,
  input  logic signed [DELTA_W-1:0] dl_w1_col_i,
  input  logic signed [DELTA_W-1:0] dl_w2_col_i,
  input  logic signed [DELTA_W-1:0] dl_w0_row_i,
  input  logic signed [DELTA_W-1:0] dl_w1_row_i,
  input  logic signed [DELTA_W-1:0] dl_w2_row_i,
  input  logic signed [EDGE_W-1:0]  w0_row_i,
  input  logic signed [EDGE_W-1:0]  w1_row_i,
  input  logic signed [EDGE_W-1:0]  w2_row_i,
  input  logic signed [COORD_W-1:0] x_min_i,
  input  logic signed [COORD_W-1:0] y_min_i,
  input  logic signed [COORD_W-1:0] x_max_i,
  input  logic signed [COORD_W-1:0] y_max_i,
  input  logic                      valid_i,
  output logic                      busy_o,
  output logic signed [COORD_W-1:0] frag_x_o,
  output logic signed [COORD_W-1:0] frag_y_o,
  output logic signed [EDGE_W-1:0]  frag_w0_o,
  output logic signed [EDGE_W-1:0]  frag_w1_o,
  output logic signed [EDGE_W-1:0]  frag_w2_o,
  output logic [AREA_W-1:0]         frag_area_o,
  output logic                      valid_o,
  input  logic                      busy_i,
  output logic                      tri_done_o
);

  localparam logic signed [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
  localparam logic signed [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);

  walker_state_t state;

  logic signed [COORD_W-1:0] x_p0, y_p0;
  logic signed [COORD_W-1:0] x_min_p0, x_max_p0, y_max_p0;
  logic [AREA_W-1:0]         area_p0;
  logic signed [EDGE_W-1:0]  w0_p0, w1_p0, w2_p0;

  frag_t frag_p1;
  logic  vld_p1;

  logic accept, load, on_screen, covered, stall, advance;
  logic at_x_end, at_y_end, step_col, step_row;

  assign accept = (state == IDLE) && valid_i;
  // Zero-area triangles skip the walk, so the steppers need not load.
  assign load   = accept && (area_i != '0);

  // Pixel evaluation on the current walk position
  assign on_screen = !x_p0[COORD_W-1] && (x_p0 < SCR_W) &&
                     !y_p0[COORD_W-1] && (y_p0 < SCR_H);
  assign covered   = (state == WALK) && on_screen && edges_inside(w0_p0, w1_p0, w2_p0);

  // Only a covered pixel needs the output slot, so uncovered pixels keep
  // walking even while downstream is stalled.
  assign stall   = covered && vld_p1 && busy_i;
  assign advance = (state == WALK) && !stall;

  assign at_x_end = (x_p0 == x_max_p0);
  assign at_y_end = (y_p0 == y_max_p0);
  assign step_col = advance && !at_x_end;
  assign step_row = advance && at_x_end && !at_y_end;

  edge_stepper u_e0 (
    .clk(clock_i), .load(load), .step_col(step_col), .step_row(step_row),
    .start(w0_row_i), .dl_col(dl_w0_col_i), .dl_row(dl_w0_row_i), .cur(w0_p0)
  );
  edge_stepper u_e1 (
    .clk(clock_i), .load(load), .step_col(step_col), .step_row(step_row),
    .start(w1_row_i), .dl_col(dl_w1_col_i), .dl_row(dl_w1_row_i), .cur(w1_p0)
  );
  edge_stepper u_e2 (
    .clk(clock_i), .load(load), .step_col(step_col), .step_row(step_row),
    .start(w2_row_i), .dl_col(dl_w2_col_i), .dl_row(dl_w2_row_i), .cur(w2_p0)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (valid_i) state <= (area_i == '0) ? DONE : WALK;
        WALK:    if (advance && at_x_end && at_y_end) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (covered && !stall) vld_p1 <= 1'b1;
      else if (!busy_i)      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (accept) begin
      x_p0     <= x_min_i;
      y_p0     <= y_min_i;
      x_min_p0 <= x_min_i;
      x_max_p0 <= x_max_i;
      y_max_p0 <= y_max_i;
      area_p0  <= area_i;
    end else if (step_row) begin
      x_p0 <= x_min_p0;
      y_p0 <= y_p0 + 12'sd1;
    end else if (step_col) begin
      x_p0 <= x_p0 + 12'sd1;
    end

    // Output register stage
    if (covered && !stall) begin
      frag_p1.x    <= x_p0;
      frag_p1.y    <= y_p0;
      frag_p1.w0   <= w0_p0;
      frag_p1.w1   <= w1_p0;
      frag_p1.w2   <= w2_p0;
      frag_p1.area <= area_p0;
    end
  end

  assign busy_o      = (state != IDLE);
  assign tri_done_o  = (state == DONE);
  assign valid_o     = vld_p1;
  assign frag_x_o    = frag_p1.x;
  assign frag_y_o    = frag_p1.y;
  assign frag_w0_o   = frag_p1.w0;
  assign frag_w1_o   = frag_p1.w1;
  assign frag_w2_o   = frag_p1.w2;
  assign frag_area_o = frag_p1.area;

endmodule

// File: tb/tb_raster_walker.sv
// Self-checking bench for raster_walker: table of setup packets with
// hand-computed fragment lists, plus stall and mid-walk reset sequences.
module tb_raster_walker;

  logic               clk;
  logic               reset_i;
  logic [23:0]        area_i;
  logic signed [16:0] dl_w0_col_i, dl_w1_col_i, dl_w2_col_i;
  logic signed [16:0] dl_w0_row_i, dl_w1_row_i, dl_w2_row_i;
  logic signed [24:0] w0_row_i, w1_row_i, w2_row_i;
  logic signed [11:0] x_min_i, y_min_i, x_max_i, y_max_i;
  logic               valid_i;
  logic               busy_o;
  logic signed [11:0] frag_x_o, frag_y_o;
  logic signed [24:0] frag_w0_o, frag_w1_o, frag_w2_o;
  logic [23:0]        frag_area_o;
  logic               valid_o;
  logic               busy_i;
  logic               tri_done_o;

  raster_walker dut (
    .clock_i(clk), .reset_i(reset_i), .area_i(area_i),
    .dl_w0_col_i(dl_w0_col_i), .dl_w1_col_i(dl_w1_col_i), .dl_w2_col_i(dl_w2_col_i),
    .dl_w0_row_i(dl_w0_row_i), .dl_w1_row_i(dl_w1_row_i), .dl_w2_row_i(dl_w2_row_i),
    .w0_row_i(w0_row_i), .w1_row_i(w1_row_i), .w2_row_i(w2_row_i),
    .x_min_i(x_min_i), .y_min_i(y_min_i), .x_max_i(x_max_i), .y_max_i(y_max_i),
    .valid_i(valid_i), .busy_o(busy_o),
    .frag_x_o(frag_x_o), .frag_y_o(frag_y_o),
    .frag_w0_o(frag_w0_o), .frag_w1_o(frag_w1_o), .frag_w2_o(frag_w2_o),
    .frag_area_o(frag_area_o), .valid_o(valid_o), .busy_i(busy_i),
    .tri_done_o(tri_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x_min, y_min, x_max, y_max;
    int w0, w1, w2;
    int dc0, dc1, dc2;
    int dr0, dr1, dr2;
    int area;
    int first_exp, n_exp;  // slice of exps[]
    int first_k;           // cycles after accept+1 until first valid_o (-1: none)
    int done_k;            // cycles after accept+1 until tri_done_o
  } vec_t;

  typedef struct {
    int x, y, w0, w1, w2;
  } exp_t;

  vec_t vecs[6];
  exp_t exps[11];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive_pkt(input vec_t v);
    x_min_i = 12'(v.x_min); y_min_i = 12'(v.y_min);
    x_max_i = 12'(v.x_max); y_max_i = 12'(v.y_max);
    w0_row_i = 25'(v.w0); w1_row_i = 25'(v.w1); w2_row_i = 25'(v.w2);
    dl_w0_col_i = 17'(v.dc0); dl_w1_col_i = 17'(v.dc1); dl_w2_col_i = 17'(v.dc2);
    dl_w0_row_i = 17'(v.dr0); dl_w1_row_i = 17'(v.dr1); dl_w2_row_i = 17'(v.dr2);
    area_i = 24'(v.area);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic run_pkt(input int vi, input bit do_stall);
    vec_t v;
    exp_t e;
    int k, n_got, first_k, done_k, sx, sy, sw1;
    bit stalled;
    v = vecs[vi];
    drive_pkt(v);
    chk($sformatf("v%0d_busy_after_accept", vi), int'(busy_o), 1);
    k = 0; n_got = 0; first_k = -1; done_k = -1; stalled = 1'b0;
    while (k < 200 && done_k < 0) begin
      if (do_stall && !stalled && valid_o && frag_x_o == 12'sd1 && frag_y_o == 12'sd0) begin
        stalled = 1'b1;
        sx = int'(frag_x_o); sy = int'(frag_y_o); sw1 = int'(frag_w1_o);
        busy_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1; k++;
          chk("stall_valid", int'(valid_o), 1);
          chk("stall_x", int'(frag_x_o), sx);
          chk("stall_y", int'(frag_y_o), sy);
          chk("stall_w1", int'(frag_w1_o), sw1);
        end
        busy_i = 1'b0;
      end
      if (valid_o && !busy_i) begin
        if (first_k < 0) first_k = k;
        if (n_got < v.n_exp) begin
          e = exps[v.first_exp + n_got];
          chk($sformatf("v%0d_f%0d_x", vi, n_got), int'(frag_x_o), e.x);
          chk($sformatf("v%0d_f%0d_y", vi, n_got), int'(frag_y_o), e.y);
          chk($sformatf("v%0d_f%0d_w0", vi, n_got), int'(frag_w0_o), e.w0);
          chk($sformatf("v%0d_f%0d_w1", vi, n_got), int'(frag_w1_o), e.w1);
          chk($sformatf("v%0d_f%0d_w2", vi, n_got), int'(frag_w2_o), e.w2);
          chk($sformatf("v%0d_f%0d_area", vi, n_got), int'(frag_area_o), v.area);
        end
        n_got++;
      end
      if (tri_done_o) done_k = k;
      else begin
        @(posedge clk); #1; k++;
      end
    end
    if (done_k < 0) chk($sformatf("v%0d_done_timeout", vi), 0, 1);
    else chk($sformatf("v%0d_done_cycle", vi), done_k, v.done_k + (do_stall ? 3 : 0));
    chk($sformatf("v%0d_frag_count", vi), n_got, v.n_exp);
    if (do_stall) chk("stall_seen", int'(stalled), 1);
    else chk($sformatf("v%0d_first_valid_cycle", vi), first_k, v.first_k);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_busy", vi), int'(busy_o), 0);
    chk($sformatf("v%0d_idle_valid", vi), int'(valid_o), 0);
    chk($sformatf("v%0d_done_single", vi), int'(tri_done_o), 0);
  endtask

  initial begin
    int done_seen;
    //                 xmn ymn xmx ymx  w0 w1 w2  dc0 dc1 dc2 dr0 dr1 dr2 area fe ne fk dk
    vecs[0] = '{  0,  0,  1,  1,  1, 5, 1,  0, -1,  0,  0,  3,  0,   1, 0, 4, 1, 4};
    vecs[1] = '{  0,  0,  2,  0,  1, 2, 3, -1,  0,  0,  0,  0,  0,   5, 4, 2, 1, 3};
    vecs[2] = '{ -2,  0,  1,  0,  1, 1, 1,  0,  0,  0,  0,  0,  0,   7, 6, 2, 3, 4};
    vecs[3] = '{638,  0,641,  0,  4, 5, 6,  2,  0,  0,  0,  0,  0,   9, 8, 2, 1, 4};
    vecs[4] = '{  5,479,  5,480, 10, 1, 1,  0,  0,  0, -3,  0,  0,   3,10, 1, 1, 2};
    vecs[5] = '{  0,  0,  9,  9,  1, 1, 1,  0,  0,  0,  0,  0,  0,   0, 0, 0,-1, 0};
    exps[0]  = '{  0,   0,  1, 5, 1};
    exps[1]  = '{  1,   0,  1, 4, 1};
    exps[2]  = '{  0,   1,  1, 8, 1};
    exps[3]  = '{  1,   1,  1, 7, 1};
    exps[4]  = '{  0,   0,  1, 2, 3};
    exps[5]  = '{  1,   0,  0, 2, 3};
    exps[6]  = '{  0,   0,  1, 1, 1};
    exps[7]  = '{  1,   0,  1, 1, 1};
    exps[8]  = '{638,   0,  4, 5, 6};
    exps[9]  = '{639,   0,  6, 5, 6};
    exps[10] = '{  5, 479, 10, 1, 1};

    reset_i = 1'b1; valid_i = 1'b0; busy_i = 1'b0;
    area_i = '0; x_min_i = '0; y_min_i = '0; x_max_i = '0; y_max_i = '0;
    w0_row_i = '0; w1_row_i = '0; w2_row_i = '0;
    dl_w0_col_i = '0; dl_w1_col_i = '0; dl_w2_col_i = '0;
    dl_w0_row_i = '0; dl_w1_row_i = '0; dl_w2_row_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(tri_done_o), 0);

    for (int i = 0; i < 6; i++) run_pkt(i, 1'b0);

    run_pkt(0, 1'b1);

    // Mid-walk reset on an 8x8 box
    drive_pkt('{0, 0, 7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pre_valid", int'(valid_o), 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(tri_done_o), 0);
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (tri_done_o || valid_o || busy_o) done_seen++;
    end
    chk("abort_quiet", done_seen, 0);

    run_pkt(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
